fios_res_collect: RTL and testbench
===================================

FIOS_RES_COLLECT -- requirements
Module: fios_res_collect

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 17, width of one FIOS result word.
REQ-002 SHALL have parameter s, default 8, number of words per operand/result.
REQ-003 SHALL have parameter REDUCE, default 1; 1 = apply final conditional subtraction of P, 0 = pass the collected result through unchanged.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clock_i  input  1  rising-edge clock.
REQ-006 reset_n_i  input  1  asynchronous active-low reset.
REQ-007 RES_i  input  WORD_WIDTH  result word from the FIOS multiplier, least-significant word first.
REQ-008 RES_push_i  input  1  RES_i valid this cycle.
REQ-009 done_i  input  1  multiplication complete pulse.
REQ-010 p_i  input  s*WORD_WIDTH  modulus P, word k at bits [k*WORD_WIDTH +: WORD_WIDTH], stable from first push until res_valid_o handshake.
REQ-011 res_o  output  s*WORD_WIDTH  reduced result, same word packing as p_i.
REQ-012 res_valid_o  output  1  res_o valid.
REQ-013 res_ready_i  input  1  consumer accepts res_o.
REQ-014 busy_o  output  1  high in any state other than COLLECT with zero words stored.
REQ-015 err_o  output  1  sticky protocol-error flag.

Function
REQ-016 SHALL implement FSM states COLLECT, SUB, HOLD; reset state COLLECT.
REQ-017 COLLECT: each cycle with RES_push_i=1 and word count wr_cnt<s SHALL write RES_i into buffer slot wr_cnt and increment wr_cnt.
REQ-018 COLLECT: RES_push_i=1 when wr_cnt==s SHALL drop the word and set err_o.
REQ-019 done_i=1 in COLLECT with (wr_cnt + RES_push_i)==s SHALL accept any coincident push, clear wr_cnt, and transition next cycle to SUB if REDUCE=1, else to HOLD with res_o = collected words.
REQ-020 done_i=1 in COLLECT with any other word count SHALL set err_o, clear wr_cnt, discard the buffer, and remain in COLLECT.
REQ-021 SUB SHALL process one word per cycle for k=0..s-1: d[k] = res[k] - p[k] - borrow (mod 2^WORD_WIDTH), borrow_out = 1 when res[k] < p[k] + borrow; borrow initialised to 0 on entering SUB.
REQ-022 After word s-1, final borrow 0 (RES >= P) SHALL select d as res_o; final borrow 1 SHALL select the unmodified collected words; transition to HOLD.
REQ-023 Latency: res_valid_o SHALL rise s+1 cycles after the cycle done_i is sampled (REDUCE=1), 1 cycle after (REDUCE=0).
REQ-024 HOLD: res_valid_o=1 and res_o stable until res_valid_o && res_ready_i; on that cycle return to COLLECT next cycle with res_valid_o=0.
REQ-025 RES_push_i or done_i asserted in SUB or HOLD SHALL be ignored and SHALL set err_o.
REQ-026 err_o SHALL clear only on reset.
REQ-027 Inputs are assumed to satisfy collected RES < 2P; no multi-step reduction is performed.

Reset
REQ-028 reset_n_i=0 SHALL immediately force state COLLECT, wr_cnt=0, borrow=0, res_valid_o=0, busy_o=0, err_o=0, res_o=0, including mid-collection or mid-SUB.
REQ-029 After reset_n_i deasserts, the first RES_push_i SHALL be stored in slot 0.

Verification (WORD_WIDTH=17, s=2, REDUCE=1, p_i words {w0=5, w1=1}, P=131077)
REQ-030 Push 7 then 1, done_i with second push -> after 3 cycles res_valid_o=1, res_o words {w0=2, w1=0}, err_o=0.
REQ-031 Push 3, 1, done_i next cycle -> res_o words {3, 1} unchanged (RES < P).
REQ-032 Push 4, 2, done_i -> borrow across words, res_o words {w0=0x1FFFF, w1=0}.
REQ-033 Hold res_ready_i=0 for 5 cycles in HOLD -> res_valid_o and res_o stable; ready=1 -> next cycle res_valid_o=0, busy_o=0.
REQ-034 Push 1 word then done_i -> err_o=1, state COLLECT, no res_valid_o; push during HOLD -> err_o=1, res_o unchanged.
REQ-035 Assert reset_n_i=0 during SUB -> all outputs 0 asynchronously; new sequence 7,1,done -> res_o {2,0}.

Source files
------------

// File: rtl/fios_res_collect.sv
// Collects s result words from a FIOS multiplier, optionally applies one conditional subtraction
// of P, and holds the reduced result on a valid/ready handshake.
module fios_res_collect #(
  parameter int unsigned WORD_WIDTH = 17,
  parameter int unsigned s          = 8,
  parameter int unsigned REDUCE     = 1
) (
  input  logic                      clock_i,
  input  logic                      reset_n_i,
  input  logic [WORD_WIDTH-1:0]     RES_i,
  input  logic                      RES_push_i,
  input  logic                      done_i,
  input  logic [s*WORD_WIDTH-1:0]   p_i,
  output logic [s*WORD_WIDTH-1:0]   res_o,
  output logic                      res_valid_o,
  input  logic                      res_ready_i,
  output logic                      busy_o,
  output logic                      err_o
);

  localparam int unsigned CntW = $clog2(s + 1);
  localparam int unsigned ResW = s * WORD_WIDTH;
  localparam logic [CntW:0] SFull = (CntW + 1)'(s);

  typedef enum logic [1:0] {StCollect, StSub, StHold} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       wr_cnt_q, wr_cnt_d;
  logic [CntW-1:0]       k_q, k_d;
  logic                  borrow_q, borrow_d;
  logic                  err_q, err_d;
  logic [WORD_WIDTH-1:0] buf_q [s];
  logic [WORD_WIDTH-1:0] buf_d [s];
  logic [WORD_WIDTH-1:0] diff_q [s];
  logic [WORD_WIDTH-1:0] diff_d [s];
  logic [ResW-1:0]       res_q, res_d;

  logic [WORD_WIDTH-1:0] cur_res, cur_p;
  logic [WORD_WIDTH:0]   cur_sub;
  logic [CntW:0]         push_total;

  // Word currently being subtracted in StSub
  always_comb begin
    cur_res = '0;
    cur_p   = '0;
    for (int i = 0; i < s; i++) begin
      if (k_q == CntW'(i)) begin
        cur_res = buf_q[i];
        cur_p   = p_i[i*WORD_WIDTH +: WORD_WIDTH];
      end
    end
  end

  // MSB of the widened difference is the borrow out of this word
  assign cur_sub    = {1'b0, cur_res} - {1'b0, cur_p} - {{WORD_WIDTH{1'b0}}, borrow_q};
  assign push_total = {1'b0, wr_cnt_q} + {{CntW{1'b0}}, RES_push_i};

  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    k_d      = k_q;
    borrow_d = borrow_q;
    err_d    = err_q;
    buf_d    = buf_q;
    diff_d   = diff_q;
    res_d    = res_q;

    unique case (state_q)
      StCollect: begin
        if (RES_push_i) begin
          if (wr_cnt_q == CntW'(s)) begin
            err_d = 1'b1;
          end else begin
            for (int i = 0; i < s; i++) begin
              if (wr_cnt_q == CntW'(i)) buf_d[i] = RES_i;
            end
            wr_cnt_d = wr_cnt_q + 1'b1;
          end
        end
        if (done_i) begin
          wr_cnt_d = '0;
          if (push_total == SFull) begin
            if (REDUCE != 0) begin
              state_d  = StSub;
              k_d      = '0;
              borrow_d = 1'b0;
            end else begin
              state_d = StHold;
              for (int i = 0; i < s; i++) res_d[i*WORD_WIDTH +: WORD_WIDTH] = buf_d[i];
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end

      StSub: begin
        if (RES_push_i || done_i) err_d = 1'b1;
        for (int i = 0; i < s; i++) begin
          if (k_q == CntW'(i)) diff_d[i] = cur_sub[WORD_WIDTH-1:0];
        end
        borrow_d = cur_sub[WORD_WIDTH];
        k_d      = k_q + 1'b1;
        if (k_q == CntW'(s - 1)) begin
          state_d = StHold;
          // Final borrow set means RES < P: keep the collected words untouched
          for (int i = 0; i < s; i++) begin
            res_d[i*WORD_WIDTH +: WORD_WIDTH] = cur_sub[WORD_WIDTH] ? buf_q[i] : diff_d[i];
          end
        end
      end

      StHold: begin
        if (RES_push_i || done_i) err_d = 1'b1;
        if (res_ready_i) state_d = StCollect;
      end

      default: state_d = StCollect;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= StCollect;
      wr_cnt_q <= '0;
      k_q      <= '0;
      borrow_q <= 1'b0;
      err_q    <= 1'b0;
      res_q    <= '0;
      for (int i = 0; i < s; i++) begin
        buf_q[i]  <= '0;
        diff_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      k_q      <= k_d;
      borrow_q <= borrow_d;
      err_q    <= err_d;
      res_q    <= res_d;
      for (int i = 0; i < s; i++) begin
        buf_q[i]  <= buf_d[i];
        diff_q[i] <= diff_d[i];
      end
    end
  end

  assign res_o       = res_q;
  assign res_valid_o = (state_q == StHold);
  assign busy_o      = !((state_q == StCollect) && (wr_cnt_q == '0));
  assign err_o       = err_q;

endmodule

// File: tb/tb_fios_res_collect.sv
// Directed bench for fios_res_collect with two 17-bit words and P = {w0=5, w1=1}.
module tb_fios_res_collect;

  localparam int unsigned W  = 17;
  localparam int unsigned S  = 2;
  localparam int unsigned RW = W * S;

  logic          clock_i = 1'b0;
  logic          reset_n_i;
  logic [W-1:0]  RES_i;
  logic          RES_push_i;
  logic          done_i;
  logic [RW-1:0] p_i;
  logic [RW-1:0] res_o;
  logic          res_valid_o;
  logic          res_ready_i;
  logic          busy_o;
  logic          err_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock_i = ~clock_i;

  assign p_i = {17'd1, 17'd5};

  fios_res_collect #(
    .WORD_WIDTH(W),
    .s         (S),
    .REDUCE    (1)
  ) u_dut (
    .clock_i    (clock_i),
    .reset_n_i  (reset_n_i),
    .RES_i      (RES_i),
    .RES_push_i (RES_push_i),
    .done_i     (done_i),
    .p_i        (p_i),
    .res_o      (res_o),
    .res_valid_o(res_valid_o),
    .res_ready_i(res_ready_i),
    .busy_o     (busy_o),
    .err_o      (err_o)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [RW-1:0] pk(input logic [W-1:0] w0, input logic [W-1:0] w1);
    return {w1, w0};
  endfunction

  task automatic step();
    @(posedge clock_i);
    #1;
  endtask

  task automatic drive(input logic push, input logic [W-1:0] d, input logic done);
    RES_push_i = push;
    RES_i      = d;
    done_i     = done;
  endtask

  task automatic do_reset();
    reset_n_i = 1'b0;
    step();
    step();
    reset_n_i = 1'b1;
  endtask

  // Push two words with done on the second, then wait out SUB into HOLD
  task automatic run_pair(input logic [W-1:0] w0, input logic [W-1:0] w1);
    drive(1'b1, w0, 1'b0);
    step();
    drive(1'b1, w1, 1'b1);
    step();
    drive(1'b0, '0, 1'b0);
    step();
    step();
  endtask

  task automatic handshake();
    res_ready_i = 1'b1;
    step();
    res_ready_i = 1'b0;
  endtask

  logic [RW-1:0] held;

  initial begin
    reset_n_i   = 1'b0;
    res_ready_i = 1'b0;
    drive(1'b0, '0, 1'b0);
    do_reset();
    check_eq("rst_valid", res_valid_o, 0);
    check_eq("rst_busy", busy_o, 0);
    check_eq("rst_err", err_o, 0);
    check_eq("rst_res", res_o, 0);

    // 7 + 1*2^17 - P = 2, with latency check
    drive(1'b1, 17'd7, 1'b0);
    step();
    check_eq("a_busy_one_word", busy_o, 1);
    drive(1'b1, 17'd1, 1'b1);
    step();
    drive(1'b0, '0, 1'b0);
    check_eq("a_valid_c1", res_valid_o, 0);
    step();
    check_eq("a_valid_c2", res_valid_o, 0);
    step();
    check_eq("a_valid_c3", res_valid_o, 1);
    check_eq("a_res", res_o, pk(17'd2, 17'd0));
    check_eq("a_err", err_o, 0);
    handshake();
    check_eq("a_valid_after", res_valid_o, 0);
    check_eq("a_busy_after", busy_o, 0);

    // RES < P: unchanged; done arrives on its own cycle
    drive(1'b1, 17'd3, 1'b0);
    step();
    drive(1'b1, 17'd1, 1'b0);
    step();
    drive(1'b0, '0, 1'b1);
    step();
    drive(1'b0, '0, 1'b0);
    check_eq("b_busy_sub", busy_o, 1);
    step();
    step();
    check_eq("b_valid", res_valid_o, 1);
    check_eq("b_res", res_o, pk(17'd3, 17'd1));
    handshake();

    // Borrow propagates: 4 - 5 wraps, 2 - 1 - 1 = 0
    run_pair(17'd4, 17'd2);
    check_eq("c_valid", res_valid_o, 1);
    check_eq("c_res", res_o, pk(17'h1FFFF, 17'd0));
    held = res_o;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("c_hold_valid", res_valid_o, 1);
      check_eq("c_hold_res", res_o, held);
    end
    handshake();
    check_eq("c_valid_after", res_valid_o, 0);
    check_eq("c_busy_after", busy_o, 0);
    check_eq("c_err", err_o, 0);

    // Third push while full is dropped and flags an error
    drive(1'b1, 17'd7, 1'b0);
    step();
    drive(1'b1, 17'd1, 1'b0);
    step();
    check_eq("d_err_before", err_o, 0);
    drive(1'b1, 17'd9, 1'b0);
    step();
    check_eq("d_err_ovf", err_o, 1);
    drive(1'b0, '0, 1'b1);
    step();
    drive(1'b0, '0, 1'b0);
    step();
    step();
    check_eq("d_valid", res_valid_o, 1);
    check_eq("d_res", res_o, pk(17'd2, 17'd0));
    handshake();

    // done with only one word stored
    do_reset();
    check_eq("e_err_cleared", err_o, 0);
    drive(1'b1, 17'd7, 1'b0);
    step();
    drive(1'b0, '0, 1'b1);
    step();
    drive(1'b0, '0, 1'b0);
    check_eq("e_err", err_o, 1);
    check_eq("e_busy", busy_o, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("e_no_valid", res_valid_o, 0);
    end

    // Push and done during HOLD are ignored
    do_reset();
    run_pair(17'd7, 17'd1);
    check_eq("f_valid", res_valid_o, 1);
    check_eq("f_err_before", err_o, 0);
    drive(1'b1, 17'd9, 1'b1);
    step();
    drive(1'b0, '0, 1'b0);
    check_eq("f_err", err_o, 1);
    check_eq("f_valid_still", res_valid_o, 1);
    check_eq("f_res_unchanged", res_o, pk(17'd2, 17'd0));
    handshake();
    check_eq("f_err_sticky", err_o, 1);

    // Asynchronous reset in the middle of SUB
    drive(1'b1, 17'd7, 1'b0);
    step();
    drive(1'b1, 17'd1, 1'b1);
    step();
    drive(1'b0, '0, 1'b0);
    check_eq("g_busy_sub", busy_o, 1);
    #2;
    reset_n_i = 1'b0;
    #1;
    check_eq("g_async_valid", res_valid_o, 0);
    check_eq("g_async_busy", busy_o, 0);
    check_eq("g_async_err", err_o, 0);
    check_eq("g_async_res", res_o, 0);
    step();
    reset_n_i = 1'b1;
    run_pair(17'd7, 17'd1);
    check_eq("g_valid", res_valid_o, 1);
    check_eq("g_res", res_o, pk(17'd2, 17'd0));
    check_eq("g_err", err_o, 0);
    handshake();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
